// File: rtl/archie_mem_pkg.sv
// -----------------------------------------------------------------------------
// archie_mem_pkg
// Shared definitions for the Archimedes memory path: grant encodings for the
// SDRAM port arbiter, wishbone cycle-type codes and the loader base address.
// Helper functions decode cycle types and loader halfword selects.
// -----------------------------------------------------------------------------
package archie_mem_pkg;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_CORE = 2'd1,
        G_LOAD = 2'd2
    } grant_t;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [2:0]  CTI_INCR    = 3'b010;
    localparam logic [2:0]  CTI_EOB     = 3'b111;

    localparam logic [25:0] LOADER_BASE_DEFAULT = 26'h0400000;

    // True when an acked beat with this cycle type finishes the transfer.
    function automatic logic cti_ends(input logic [2:0] cti);
        return (cti == CTI_CLASSIC) || (cti == CTI_EOB);
    endfunction

    // Byte lanes for a 16-bit loader halfword placed in a 32-bit word.
    function automatic logic [3:0] ld_sel(input logic upper_half);
        return upper_half ? 4'b1100 : 4'b0011;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_ld_hold_reg.sv
// -----------------------------------------------------------------------------
// ld_hold_reg
// Single-entry holding register for the HPS loader write stream. A strobe is
// captured when the loader window is open and the entry is free (or being
// drained this same cycle); a strobe that finds the entry occupied is dropped
// and flagged as an overflow.
//
// Ports:
//   clk_sys    in   system clock
//   reset      in   synchronous, active-high
//   ld_active  in   loader download window
//   ld_wr      in   one-cycle loader write strobe
//   ld_addr    in   [23:0] loader byte address
//   ld_data    in   [15:0] loader write data
//   drain      in   held word has been consumed (acked or aborted)
//   pending    out  a word is held
//   hold_addr  out  [22:0] held address bits [23:1]
//   hold_data  out  [15:0] held data
//   overflow   out  strobe dropped this cycle
// -----------------------------------------------------------------------------
module ld_hold_reg
    import archie_mem_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic [23:0] ld_addr,
    input  logic [15:0] ld_data,
    input  logic        drain,
    output logic        pending,
    output logic [22:0] hold_addr,
    output logic [15:0] hold_data,
    output logic        overflow
);

    logic pending_r;
    logic capture_s;
    logic unused_addr_bit;

    // Byte lane within a halfword is irrelevant for 16-bit writes.
    assign unused_addr_bit = ld_addr[0];

    // A drain in the same cycle frees the entry for a new capture.
    assign capture_s = ld_wr && ld_active && (!pending_r || drain);
    assign overflow  = ld_wr && ld_active && pending_r && !drain;
    assign pending   = pending_r;

    // Holding register and pending flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pending_r <= 1'b0;
            hold_addr <= 23'd0;
            hold_data <= 16'd0;
        end else if (capture_s) begin
            pending_r <= 1'b1;
            hold_addr <= ld_addr[23:1];
            hold_data <= ld_data;
        end else if (drain) begin
            pending_r <= 1'b0;
        end else begin
            pending_r <= pending_r;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// ram_port_arbiter
// Shares the SDRAM wishbone port between the CPU/video core master and the HPS
// ROM loader. A registered IDLE/CORE/LOAD scheduler grants one requester at a
// time with a one-cycle turnaround, alternates on contention so neither side
// starves, and aborts any grant that waits too long for m_ack.
//
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   ld_active/ld_wr/ld_addr/ld_data   loader stream in
//   ld_wait                 loader hold-off (word pending or in flight)
//   c_stb/c_we/c_sel/c_adr/c_dat/c_cti  core wishbone master in
//   c_ack                   ack back to core
//   m_stb/m_cyc/m_we/m_sel/m_adr/m_dat/m_cti  wishbone to SDRAM controller
//   m_ack                   ack from SDRAM controller
//   err                     sticky timeout / loader overflow flag
// -----------------------------------------------------------------------------
module ram_port_arbiter
    import archie_mem_pkg::*;
#(
    parameter logic [25:0] LOADER_BASE = LOADER_BASE_DEFAULT,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ld_active,
    input  logic        ld_wr,
    input  logic [23:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        ld_wait,
    input  logic        c_stb,
    input  logic        c_we,
    input  logic [3:0]  c_sel,
    input  logic [21:0] c_adr,
    input  logic [31:0] c_dat,
    input  logic [2:0]  c_cti,
    output logic        c_ack,
    output logic        m_stb,
    output logic        m_cyc,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [25:0] m_adr,
    output logic [31:0] m_dat,
    output logic [2:0]  m_cti,
    input  logic        m_ack,
    output logic        err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CORE = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic [1:0]  state_r;
    logic [1:0]  state_nx;
    grant_t      last_grant_r;
    grant_t      grant_nx;
    logic [7:0]  tmo_cnt_r;
    logic        tmo_s;
    logic        drain_s;
    logic        pending_s;
    logic        overflow_s;
    logic [22:0] hold_addr_s;
    logic [15:0] hold_data_s;

    ld_hold_reg u_hold (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .drain     (drain_s),
        .pending   (pending_s),
        .hold_addr (hold_addr_s),
        .hold_data (hold_data_s),
        .overflow  (overflow_s)
    );

    // The counter reaching the limit while granted aborts the transfer; the
    // strobe is already dropped in that abort cycle.
    assign tmo_s   = (state_r != ST_IDLE) && (tmo_cnt_r == TMO_LIMIT);
    assign drain_s = (state_r == ST_LOAD) && (m_ack || tmo_s);
    assign ld_wait = pending_s;

    // Next-state and grant scheduling.
    always_comb begin
        state_nx = state_r;
        grant_nx = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                // Loader wins right after a core grant or when the core is
                // quiet; otherwise a requesting core wins, which also covers
                // the loader having just been served.
                if (pending_s && ((last_grant_r == G_CORE) || !c_stb)) begin
                    state_nx = ST_LOAD;
                    grant_nx = G_LOAD;
                end else if (c_stb) begin
                    state_nx = ST_CORE;
                    grant_nx = G_CORE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CORE: begin
                if (tmo_s || !c_stb || (m_ack && cti_ends(c_cti))) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_CORE;
                end
            end
            ST_LOAD: begin
                if (tmo_s || m_ack) begin
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_LOAD;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and last-grant registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            last_grant_r <= G_IDLE;
        end else begin
            state_r      <= state_nx;
            last_grant_r <= grant_nx;
        end
    end

    // Ack-wait counter: restarts on every grant and every ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == ST_IDLE) || m_ack) begin
            tmo_cnt_r <= 8'd0;
        end else if (tmo_cnt_r != TMO_LIMIT) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // Sticky error flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            err <= 1'b0;
        end else if (tmo_s || overflow_s) begin
            err <= 1'b1;
        end else begin
            err <= err;
        end
    end

    // Memory-side mux; the core path is combinational pass-through.
    always_comb begin
        m_stb = 1'b0;
        m_cyc = 1'b0;
        m_we  = 1'b0;
        m_sel = 4'b0000;
        m_adr = 26'd0;
        m_dat = 32'd0;
        m_cti = 3'b000;
        c_ack = 1'b0;
        case (state_r)
            ST_CORE: begin
                m_stb = c_stb && !tmo_s;
                m_cyc = c_stb && !tmo_s;
                m_we  = c_we;
                m_sel = c_sel;
                m_adr = {2'b00, c_adr, 2'b00};
                m_dat = c_dat;
                m_cti = c_cti;
                c_ack = m_ack && !tmo_s;
            end
            ST_LOAD: begin
                m_stb = !tmo_s;
                m_cyc = !tmo_s;
                m_we  = 1'b1;
                m_sel = ld_sel(hold_addr_s[0]);
                m_adr = LOADER_BASE + {2'b00, hold_addr_s[22:1], 2'b00};
                m_dat = {hold_data_s, hold_data_s};
                m_cti = CTI_CLASSIC;
            end
            default: begin
                m_stb = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ram_port_arbiter
// Directed bench for ram_port_arbiter: loader-only write, core burst,
// contention, overflow, ld_active gating, timeout and reset mid-transfer.
// Inputs change 2 time units after the rising edge; outputs are sampled 1 unit
// later.
// -----------------------------------------------------------------------------
module tb_ram_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ld_active;
    logic        ld_wr;
    logic [23:0] ld_addr;
    logic [15:0] ld_data;
    logic        ld_wait;
    logic        c_stb;
    logic        c_we;
    logic [3:0]  c_sel;
    logic [21:0] c_adr;
    logic [31:0] c_dat;
    logic [2:0]  c_cti;
    logic        c_ack;
    logic        m_stb;
    logic        m_cyc;
    logic        m_we;
    logic [3:0]  m_sel;
    logic [25:0] m_adr;
    logic [31:0] m_dat;
    logic [2:0]  m_cti;
    logic        m_ack;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int hi_cnt   = 0;

    ram_port_arbiter dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ld_active (ld_active),
        .ld_wr     (ld_wr),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_wait   (ld_wait),
        .c_stb     (c_stb),
        .c_we      (c_we),
        .c_sel     (c_sel),
        .c_adr     (c_adr),
        .c_dat     (c_dat),
        .c_cti     (c_cti),
        .c_ack     (c_ack),
        .m_stb     (m_stb),
        .m_cyc     (m_cyc),
        .m_we      (m_we),
        .m_sel     (m_sel),
        .m_adr     (m_adr),
        .m_dat     (m_dat),
        .m_cti     (m_cti),
        .m_ack     (m_ack),
        .err       (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ld_active = 1'b0; ld_wr = 1'b0; ld_addr = 24'd0; ld_data = 16'd0;
        c_stb = 1'b0; c_we = 1'b0; c_sel = 4'd0; c_adr = 22'd0; c_dat = 32'd0;
        c_cti = 3'd0; m_ack = 1'b0;
        tick(); tick();

        // Reset state
        #1;
        chk("rst_m_stb", {31'd0, m_stb}, 32'd0);
        chk("rst_m_cyc", {31'd0, m_cyc}, 32'd0);
        chk("rst_m_we", {31'd0, m_we}, 32'd0);
        chk("rst_m_sel", {28'd0, m_sel}, 32'd0);
        chk("rst_m_adr", {6'd0, m_adr}, 32'd0);
        chk("rst_m_dat", m_dat, 32'd0);
        chk("rst_m_cti", {29'd0, m_cti}, 32'd0);
        chk("rst_c_ack", {31'd0, c_ack}, 32'd0);
        chk("rst_ld_wait", {31'd0, ld_wait}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick();

        // Loader only: halfword at 0x000006
        ld_active = 1'b1; ld_wr = 1'b1; ld_addr = 24'h000006; ld_data = 16'hBEEF;
        #1 chk("ld_wait_capture_cycle", {31'd0, ld_wait}, 32'd0);
        tick();
        ld_wr = 1'b0;
        #1 chk("ld_wait_idle", {31'd0, ld_wait}, 32'd1);
        chk("ld_idle_stb", {31'd0, m_stb}, 32'd0);
        tick();
        #1;
        chk("ld_m_stb", {31'd0, m_stb}, 32'd1);
        chk("ld_m_cyc", {31'd0, m_cyc}, 32'd1);
        chk("ld_m_we", {31'd0, m_we}, 32'd1);
        chk("ld_m_adr", {6'd0, m_adr}, 32'h00400004);
        chk("ld_m_sel", {28'd0, m_sel}, 32'hC);
        chk("ld_m_dat", m_dat, 32'hBEEFBEEF);
        chk("ld_m_cti", {29'd0, m_cti}, 32'd0);
        chk("ld_c_ack", {31'd0, c_ack}, 32'd0);
        tick();
        #1 chk("ld_stb_wait2", {31'd0, m_stb}, 32'd1);
        tick();
        m_ack = 1'b1;
        #1 chk("ld_c_ack_on_mack", {31'd0, c_ack}, 32'd0);
        chk("ld_wait_ack_cycle", {31'd0, ld_wait}, 32'd1);
        tick();
        m_ack = 1'b0; ld_active = 1'b0;
        #1 chk("ld_wait_released", {31'd0, ld_wait}, 32'd0);
        chk("ld_done_stb", {31'd0, m_stb}, 32'd0);
        tick();

        // Core burst of 4 beats at word 0x1000
        c_stb = 1'b1; c_we = 1'b1; c_sel = 4'hF; c_cti = 3'b010;
        c_adr = 22'h001000; c_dat = 32'h11223344;
        #1 chk("burst_turnaround", {31'd0, m_stb}, 32'd0);
        tick();
        m_ack = 1'b1;
        #1;
        chk("burst_b1_stb", {31'd0, m_stb}, 32'd1);
        chk("burst_m_adr", {6'd0, m_adr}, 32'h00004000);
        chk("burst_m_dat", m_dat, 32'h11223344);
        chk("burst_m_sel", {28'd0, m_sel}, 32'hF);
        chk("burst_m_cti", {29'd0, m_cti}, 32'd2);
        chk("burst_b1_ack", {31'd0, c_ack}, 32'd1);
        tick();
        c_dat = 32'h55667788;
        #1 chk("burst_b2_ack", {31'd0, c_ack}, 32'd1);
        chk("burst_b2_dat", m_dat, 32'h55667788);
        tick();
        #1 chk("burst_b3_ack", {31'd0, c_ack}, 32'd1);
        tick();
        c_cti = 3'b111;
        #1 chk("burst_b4_ack", {31'd0, c_ack}, 32'd1);
        chk("burst_b4_stb", {31'd0, m_stb}, 32'd1);
        chk("burst_b4_cti", {29'd0, m_cti}, 32'd7);
        tick();
        c_stb = 1'b0; c_cti = 3'd0; m_ack = 1'b0; c_we = 1'b0;
        #1 chk("burst_idle_stb", {31'd0, m_stb}, 32'd0);
        chk("burst_idle_ack", {31'd0, c_ack}, 32'd0);
        tick();

        // Contention: loader word arrives mid-burst
        c_stb = 1'b1; c_we = 1'b1; c_sel = 4'hF; c_cti = 3'b010; c_adr = 22'h000020;
        #1 chk("cont_turnaround", {31'd0, m_stb}, 32'd0);
        tick();
        m_ack = 1'b1; ld_active = 1'b1; ld_wr = 1'b1; ld_addr = 24'h000100; ld_data = 16'h1234;
        #1 chk("cont_b1_ack", {31'd0, c_ack}, 32'd1);
        tick();
        ld_wr = 1'b0; c_cti = 3'b111;
        #1 chk("cont_grant_held", {31'd0, m_stb}, 32'd1);
        chk("cont_core_adr", {6'd0, m_adr}, 32'h00000080);
        chk("cont_ld_wait", {31'd0, ld_wait}, 32'd1);
        tick();
        m_ack = 1'b0; c_cti = 3'b000; c_adr = 22'h000030;
        #1 chk("cont_idle", {31'd0, m_stb}, 32'd0);
        tick();
        m_ack = 1'b1;
        #1 chk("cont_load_adr", {6'd0, m_adr}, 32'h00400100);
        chk("cont_load_sel", {28'd0, m_sel}, 32'h3);
        chk("cont_load_dat", m_dat, 32'h12341234);
        chk("cont_load_cack", {31'd0, c_ack}, 32'd0);
        tick();
        m_ack = 1'b0;
        #1 chk("cont_idle2", {31'd0, m_stb}, 32'd0);
        chk("cont_wait_clear", {31'd0, ld_wait}, 32'd0);
        tick();
        m_ack = 1'b1;
        #1 chk("cont_core_regrant", {6'd0, m_adr}, 32'h000000C0);
        chk("cont_core_ack", {31'd0, c_ack}, 32'd1);
        tick();
        c_stb = 1'b0; m_ack = 1'b0; c_we = 1'b0;
        #1 chk("cont_end", {31'd0, m_stb}, 32'd0);
        tick();

        // Overflow, then a capture coinciding with the LOAD ack
        ld_wr = 1'b1; ld_addr = 24'h000010; ld_data = 16'hAAAA;
        #1 chk("ovf_err_before", {31'd0, err}, 32'd0);
        tick();
        ld_wr = 1'b0;
        #1 chk("ovf_idle", {31'd0, m_stb}, 32'd0);
        tick();
        ld_wr = 1'b1; ld_addr = 24'h000020; ld_data = 16'h5555;
        #1 chk("ovf_first_adr", {6'd0, m_adr}, 32'h00400010);
        tick();
        ld_wr = 1'b1; ld_addr = 24'h000024; ld_data = 16'h9999; m_ack = 1'b1;
        #1 chk("ovf_err_set", {31'd0, err}, 32'd1);
        chk("ovf_kept_dat", m_dat, 32'hAAAAAAAA);
        chk("ovf_kept_adr", {6'd0, m_adr}, 32'h00400010);
        tick();
        ld_wr = 1'b0; m_ack = 1'b0;
        #1 chk("same_cycle_capture", {31'd0, ld_wait}, 32'd1);
        chk("same_cycle_idle", {31'd0, m_stb}, 32'd0);
        tick();
        m_ack = 1'b1;
        #1 chk("same_cycle_adr", {6'd0, m_adr}, 32'h00400024);
        chk("same_cycle_dat", m_dat, 32'h99999999);
        chk("same_cycle_sel", {28'd0, m_sel}, 32'h3);
        tick();
        m_ack = 1'b0;
        #1 chk("ovf_wait_clear", {31'd0, ld_wait}, 32'd0);
        tick();
        #1 chk("ovf_no_extra_write", {31'd0, m_stb}, 32'd0);

        // Strobes outside the download window are ignored
        ld_active = 1'b0; ld_wr = 1'b1; ld_addr = 24'h000050;
        tick();
        ld_wr = 1'b0;
        #1 chk("inactive_ignored", {31'd0, ld_wait}, 32'd0);
        tick();
        #1 chk("inactive_no_write", {31'd0, m_stb}, 32'd0);

        // Timeout on a LOAD that never gets acked
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1 chk("tmo_err_cleared", {31'd0, err}, 32'd0);
        ld_active = 1'b1; ld_wr = 1'b1; ld_addr = 24'h000040; ld_data = 16'h0F0F;
        tick();
        ld_wr = 1'b0;
        tick();
        hi_cnt = 0;
        for (int i = 0; i < 255; i++) begin
            #1;
            if (m_stb) hi_cnt++;
            tick();
        end
        chk("tmo_stb_cycles", hi_cnt, 32'd255);
        #1 chk("tmo_stb_dropped", {31'd0, m_stb}, 32'd0);
        tick();
        #1 chk("tmo_err", {31'd0, err}, 32'd1);
        chk("tmo_wait_released", {31'd0, ld_wait}, 32'd0);
        chk("tmo_idle", {31'd0, m_stb}, 32'd0);
        tick();

        // Reset in the middle of a LOAD
        ld_wr = 1'b1; ld_addr = 24'h000002; ld_data = 16'h7777;
        tick();
        ld_wr = 1'b0;
        tick();
        #1 chk("rstmid_stb_before", {31'd0, m_stb}, 32'd1);
        reset = 1'b1;
        tick();
        #1 chk("rstmid_stb", {31'd0, m_stb}, 32'd0);
        chk("rstmid_wait", {31'd0, ld_wait}, 32'd0);
        chk("rstmid_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        tick();
        tick();
        #1 chk("rstmid_no_write", {31'd0, m_stb}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
